// File: rtl/exp_requester.sv
// Str/Ack initiator for the softmax exponential unit. Operands are queued, issued one at a
// time as a level-held request, and the results return on a valid/ready stream.
module exp_requester #(
  parameter int DATALENGTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255,
  parameter int GAP        = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATALENGTH-1:0] InData,
  input  logic                  InLast,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATALENGTH-1:0] OutData,
  output logic                  OutLast,
  output logic                  ExpStr,
  output logic [DATALENGTH-1:0] ExpDatain,
  input  logic                  ExpAck,
  input  logic [DATALENGTH-1:0] ExpDataOut,
  output logic                  Busy,
  output logic                  TimeoutErr,
  output logic [15:0]           ElemCount
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP + 1);
  localparam logic [DATALENGTH-1:0] QNAN = DATALENGTH'(32'h7fc0_0000);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  state_t                state, state_d;
  logic [DATALENGTH-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]      fifo_last;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic                  out_fire, out_free;
  logic                  take_ack, take_timeout;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  last_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign InReady    = !fifo_full;
  assign push       = InValid && !fifo_full;
  assign out_fire   = OutValid && OutReady;
  assign out_free   = !OutValid || OutReady;
  assign Busy       = !fifo_empty || (state != ST_IDLE);

  // NOTE: the storage array has no reset; only the pointers decide which entries are live.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data[wr_ptr[AW-1:0]] <= InData;
      fifo_last[wr_ptr[AW-1:0]] <= InLast;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    take_ack     = 1'b0;
    take_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && out_free) begin
          pop     = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ExpAck) begin
          take_ack = 1'b1;
          state_d  = ST_GAP;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          take_timeout = 1'b1;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ExpStr     <= 1'b0;
      ExpDatain  <= '0;
      last_q     <= 1'b0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      OutValid   <= 1'b0;
      OutData    <= '0;
      OutLast    <= 1'b0;
      TimeoutErr <= 1'b0;
      ElemCount  <= '0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ExpDatain <= fifo_data[rd_ptr[AW-1:0]];
        last_q    <= fifo_last[rd_ptr[AW-1:0]];
        ExpStr    <= 1'b1;
        wait_cnt  <= '0;
      end else if (state == ST_REQ) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // The output register is always free while a request is outstanding.
      if (take_ack || take_timeout) begin
        ExpStr   <= 1'b0;
        OutValid <= 1'b1;
        OutData  <= take_ack ? ExpDataOut : QNAN;
        OutLast  <= last_q;
        gap_cnt  <= '0;
      end else begin
        if (out_fire) OutValid <= 1'b0;
        if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      end

      if (take_timeout) TimeoutErr <= 1'b1;

      if (out_fire) ElemCount <= OutLast ? 16'd0 : ElemCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_exp_requester.sv
// Self-checking bench for exp_requester: a behavioural exponential-unit model and a
// transaction-level scoreboard judge every request, result and status output.
module tb_exp_requester;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;
  localparam int GAP     = 1;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] InData = '0;
  logic        InLast = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutData;
  logic        OutLast;
  logic        ExpStr;
  logic [31:0] ExpDatain;
  logic        ExpAck = 1'b0;
  logic [31:0] ExpDataOut = '0;
  logic        Busy;
  logic        TimeoutErr;
  logic [15:0] ElemCount;

  exp_requester #(.DATALENGTH(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData), .InLast(InLast),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
    .ExpStr(ExpStr), .ExpDatain(ExpDatain), .ExpAck(ExpAck), .ExpDataOut(ExpDataOut),
    .Busy(Busy), .TimeoutErr(TimeoutErr), .ElemCount(ElemCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [31:0] data; logic last; } op_t;
  typedef struct packed { logic [31:0] data; logic last; logic tmo; } res_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ref(input logic [31:0] x);
    case (x)
      32'h3f80_0000: exp_ref = 32'h402d_f854;  // e^1
      32'h3f00_0000: exp_ref = 32'h3fd3_094c;  // e^0.5
      32'h0000_0000: exp_ref = 32'h3f80_0000;  // e^0
      32'hbf80_0000: exp_ref = 32'h3ebc_5ab2;  // e^-1
      default:       exp_ref = {x[15:0], x[31:16]} ^ 32'h5a5a_a5a5;
    endcase
  endfunction

  // Bench controls, written only by the main sequence.
  logic ack_en = 1'b1, spur_low = 1'b0, lat_rand = 1'b0;
  logic rand_ready = 1'b0, ready_force = 1'b0, check_period = 1'b0, mon_en = 1'b0;
  int   lat_cfg = 5;
  int   n_exp = 0;
  int   n_done = 0;

  // Exponential unit: acks in the cur_lat-th cycle of Str high; optionally acks whenever Str is low.
  int cur_lat = 1;
  int str_cyc = 0;
  always @(posedge Clock) begin
    #1;
    if (ExpStr === 1'b1) str_cyc++; else str_cyc = 0;
    if (str_cyc == 1) cur_lat = lat_rand ? int'($urandom_range(1, 30)) : lat_cfg;
    ExpAck     = (ack_en && str_cyc != 0 && str_cyc == cur_lat) || (spur_low && ExpStr !== 1'b1);
    ExpDataOut = (ExpStr === 1'b1) ? exp_ref(ExpDatain) : $urandom;
  end

  always @(posedge Clock) begin
    #1;
    OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Transaction-level model of the requester.
  op_t         op_q[$];
  res_t        res_q[$];
  op_t         cur_op;
  res_t        r;
  logic        tmo;
  int          occ, hi_len, low_len, exp_len, cyc, last_rise;
  logic [15:0] m_cnt;
  logic        m_terr, had_fall, prev_str, prev_ov, prev_hold, hold_last, push_pend, rst_q;
  logic [31:0] hold_data;

  task model_clear;
    op_q.delete();
    res_q.delete();
    occ = 0; hi_len = 0; low_len = 0; last_rise = -1;
    m_cnt = '0; m_terr = 1'b0; had_fall = 1'b0;
    prev_str = 1'b0; prev_ov = 1'b0; prev_hold = 1'b0; push_pend = 1'b0;
  endtask

  initial begin
    model_clear();
    cyc = 0; exp_len = 0; rst_q = 1'b1; cur_op = '0; r = '0; tmo = 1'b0;
    hold_data = '0; hold_last = 1'b0;
  end

  always @(negedge Clock) begin
    cyc++;
    if (!check_period) last_rise = -1;
    if (!mon_en || rst_q) begin
      model_clear();
    end else begin
      occ += int'(push_pend);
      if (ExpStr === 1'b1) begin
        if (!prev_str) begin
          check("issue_has_operand", op_q.size() != 0, 1);
          check("issue_out_free", OutValid, 0);
          if (op_q.size() != 0) begin
            cur_op = op_q.pop_front();
            occ--;
            tmo     = !(ack_en && cur_lat <= TIMEOUT);
            exp_len = tmo ? TIMEOUT : cur_lat;
            r.data  = tmo ? QNAN : exp_ref(cur_op.data);
            r.last  = cur_op.last;
            r.tmo   = tmo;
            res_q.push_back(r);
          end
          if (had_fall) check("gap_min", low_len >= GAP, 1);
          if (check_period && last_rise >= 0) check("req_period", cyc - last_rise, lat_cfg + GAP + 1);
          last_rise = cyc;
          hi_len = 0;
        end
        hi_len++;
        low_len = 0;
        check("datain_stable", ExpDatain, cur_op.data);
      end else begin
        if (prev_str) begin
          check("str_len", hi_len, exp_len);
          had_fall = 1'b1;
          low_len  = 0;
        end
        low_len++;
      end
    end

    if (mon_en) begin
      check("in_ready", InReady, occ < DEPTH);
      check("elem_count", ElemCount, m_cnt);
      check("busy", Busy, (occ > 0) || (ExpStr === 1'b1) || (had_fall && low_len <= GAP));
      if (OutValid && !prev_ov) check("ov_has_result", res_q.size() != 0, 1);
      if (prev_hold) begin
        check("hold_valid", OutValid, 1);
        check("hold_data", OutData, hold_data);
        check("hold_last", OutLast, hold_last);
      end
      if (OutValid && OutReady) begin
        check("hs_has_result", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          check("out_data", OutData, r.data);
          check("out_last", OutLast, r.last);
          m_terr = m_terr | r.tmo;
          check("timeout_err", TimeoutErr, m_terr);
          m_cnt = r.last ? 16'd0 : m_cnt + 16'd1;
          n_done++;
        end
      end
    end

    push_pend = mon_en && InValid && (InReady === 1'b1) && !Reset;
    if (push_pend) op_q.push_back({InData, InLast});
    prev_str  = (ExpStr === 1'b1);
    prev_ov   = (OutValid === 1'b1);
    prev_hold = mon_en && (OutValid === 1'b1) && !OutReady;
    hold_data = OutData;
    hold_last = OutLast;
    rst_q     = Reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    InData = d; InLast = l; InValid = 1'b1;
    @(negedge Clock);
    while (!InReady && n < 3000) begin
      n++;
      @(negedge Clock);
    end
    if (!InReady) check("push_accept_timeout", 0, 1);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    n_exp++;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!(!Busy && !OutValid && n_done == n_exp) && n < 5000);
    check("drain_done", !Busy && !OutValid && n_done == n_exp, 1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_exp_str"},     ExpStr, 0);
    check({pfx, "_exp_datain"},  ExpDatain, 0);
    check({pfx, "_out_valid"},   OutValid, 0);
    check({pfx, "_out_data"},    OutData, 0);
    check({pfx, "_out_last"},    OutLast, 0);
    check({pfx, "_timeout_err"}, TimeoutErr, 0);
    check({pfx, "_elem_count"},  ElemCount, 0);
    check({pfx, "_busy"},        Busy, 0);
    check({pfx, "_in_ready"},    InReady, 1);
  endtask

  initial begin
    int n;
    logic [31:0] vec4 [4];
    vec4[0] = 32'h3f80_0000; vec4[1] = 32'h3f00_0000;
    vec4[2] = 32'h0000_0000; vec4[3] = 32'hbf80_0000;

    // Power-on reset.
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    @(negedge Clock);
    check_all_zero("rst");
    tick(1);
    mon_en = 1'b1;
    ready_force = 1'b1;
    tick(2);

    // Single element, 141-cycle unit latency.
    lat_cfg = 141;
    push(32'h3f80_0000, 1'b1);
    drain();

    // Four back-to-back elements: order, OutLast, ElemCount, request spacing.
    lat_cfg = 5;
    check_period = 1'b1;
    for (int i = 0; i < 4; i++) push(vec4[i], i == 3);
    drain();
    check_period = 1'b0;

    // Downstream stalled: one result held, FIFO fills, nothing lost afterwards.
    ready_force = 1'b0;
    lat_cfg = 10;
    for (int i = 0; i < 5; i++) push(32'h4000_0000 + 32'(i), 1'b0);
    InData = 32'h4000_0005; InLast = 1'b1; InValid = 1'b1;
    tick(500);
    @(negedge Clock);
    check("stall_in_ready", InReady, 0);
    check("stall_out_valid", OutValid, 1);
    check("stall_no_req", ExpStr, 0);
    tick(1);
    ready_force = 1'b1;
    push(32'h4000_0005, 1'b1);
    drain();

    // Unit never acks: timeout result, sticky error, then normal service.
    ack_en = 1'b0;
    push(32'h4100_0000, 1'b0);
    drain();
    @(negedge Clock);
    check("terr_set", TimeoutErr, 1);
    tick(1);
    ack_en = 1'b1;
    push(32'h3f00_0000, 1'b1);
    drain();
    @(negedge Clock);
    check("terr_sticky", TimeoutErr, 1);
    tick(1);

    // Randomized operands, latencies, vector boundaries and downstream backpressure.
    rand_ready = 1'b1;
    lat_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push($urandom, ($urandom_range(0, 4) == 0) || (i == 39));
      repeat ($urandom_range(0, 2)) tick(1);
    end
    drain();
    rand_ready = 1'b0;
    lat_rand = 1'b0;
    tick(2);

    // Ack held high while Str is low (IDLE and GAP) must be ignored.
    spur_low = 1'b1;
    lat_cfg = 4;
    tick(10);
    @(negedge Clock);
    check("spur_idle_no_valid", OutValid, 0);
    check("spur_idle_no_req", ExpStr, 0);
    tick(1);
    for (int i = 0; i < 3; i++) push(vec4[i], i == 2);
    drain();
    spur_low = 1'b0;
    tick(2);

    // Reset in the 50th request cycle, then a late ack at cycle 141.
    ack_en = 1'b0;
    push(32'h3f80_0000, 1'b1);
    n = 0;
    while (ExpStr !== 1'b1 && n < 100) begin
      n++;
      @(negedge Clock);
    end
    check("rreq_started", ExpStr, 1);
    repeat (49) @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check_all_zero("mid_rst");
    repeat (90) @(posedge Clock);
    #1 spur_low = 1'b1;
    @(posedge Clock);
    #1 spur_low = 1'b0;
    tick(20);
    @(negedge Clock);
    check("late_ack_no_valid", OutValid, 0);
    check("late_ack_idle", Busy, 0);
    tick(1);
    n_exp = n_done;
    ack_en = 1'b1;
    lat_cfg = 3;
    push(32'hbf80_0000, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
